// File: rtl/bomb_controller.sv
// Single-bomb lifecycle (place, fuse, explode, idle) plus registered per-pixel
// bomb and explosion draw requests for the object priority mux.
module bomb_controller #(
  parameter int         FUSE_FRAMES     = 120,
  parameter int         EXPLODE_FRAMES  = 30,
  parameter int         RANGE           = 2,
  parameter int         BLINK_FRAMES    = 32,
  parameter logic [7:0] BOMB_COLOR      = 8'h00,
  parameter logic [7:0] FLASH_COLOR     = 8'hE0,
  parameter logic [7:0] EXPLOSION_COLOR = 8'hF4
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        placeBomb,
  input  logic [4:0]  playerTileX,
  input  logic [3:0]  playerTileY,
  input  logic        detonate,
  output logic        bombDrawingRequest,
  output logic [7:0]  bombRGB,
  output logic        explosionDrawingRequest,
  output logic [7:0]  explosionRGB,
  output logic        explodeStart,
  output logic        bombActive
);

  typedef enum logic [1:0] {IDLE, FUSE, EXPLODE} state_t;

  localparam logic [7:0]        FUSE_N  = 8'(FUSE_FRAMES);
  localparam logic [7:0]        EXP_N   = 8'(EXPLODE_FRAMES);
  localparam logic [7:0]        BLINK_N = 8'(BLINK_FRAMES);
  localparam logic signed [5:0] RNG     = 6'(RANGE);

  state_t      state;
  logic [7:0]  fuseCnt, expCnt;
  logic [4:0]  bombX;
  logic [3:0]  bombY;
  logic [1:0]  blinkCnt;
  logic        blinkPhase;

  logic              onScreen, inBodyX, inBodyY, blinkOn, fuseEnd;
  logic              bombHit, expHit;
  logic [4:0]        tx, ty;
  logic signed [5:0] dx, dy, adx, ady;

  assign tx       = pixelX[9:5];
  assign ty       = pixelY[9:5];
  assign onScreen = (pixelX < 11'd640) && (pixelY < 11'd480);
  assign inBodyX  = (pixelX[4:0] >= 5'd4) && (pixelX[4:0] <= 5'd27);
  assign inBodyY  = (pixelY[4:0] >= 5'd4) && (pixelY[4:0] <= 5'd27);
  assign blinkOn  = fuseCnt <= BLINK_N;

  // Signed tile distances; off-grid tiles are never on screen, so no wrap handling
  assign dx  = $signed({1'b0, tx}) - $signed({1'b0, bombX});
  assign dy  = $signed({1'b0, ty}) - $signed({2'b00, bombY});
  assign adx = dx[5] ? -dx : dx;
  assign ady = dy[5] ? -dy : dy;

  assign fuseEnd = (state == FUSE) && (detonate || (startOfFrame && fuseCnt == 8'd1));
  assign bombHit = (state == FUSE) && onScreen && (tx == bombX) && (ty == {1'b0, bombY})
                   && inBodyX && inBodyY;
  assign expHit  = (state == EXPLODE) && onScreen &&
                   (((dy == 6'sd0) && (adx <= RNG)) || ((dx == 6'sd0) && (ady <= RNG)));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state                   <= IDLE;
      fuseCnt                 <= '0;
      expCnt                  <= '0;
      bombX                   <= '0;
      bombY                   <= '0;
      blinkCnt                <= '0;
      blinkPhase              <= 1'b0;
      bombDrawingRequest      <= 1'b0;
      bombRGB                 <= '0;
      explosionDrawingRequest <= 1'b0;
      explosionRGB            <= '0;
      explodeStart            <= 1'b0;
      bombActive              <= 1'b0;
    end else begin
      explodeStart            <= 1'b0;
      bombDrawingRequest      <= bombHit;
      bombRGB                 <= bombHit ? ((blinkOn && blinkPhase) ? FLASH_COLOR : BOMB_COLOR) : 8'h00;
      explosionDrawingRequest <= expHit;
      explosionRGB            <= expHit ? EXPLOSION_COLOR : 8'h00;
      case (state)
        IDLE: if (placeBomb) begin
          bombX      <= playerTileX;
          bombY      <= playerTileY;
          fuseCnt    <= FUSE_N;
          blinkCnt   <= '0;
          blinkPhase <= 1'b0;
          state      <= FUSE;
          bombActive <= 1'b1;
        end
        FUSE: begin
          if (fuseEnd) begin
            state        <= EXPLODE;
            expCnt       <= EXP_N;
            explodeStart <= 1'b1;
          end else if (startOfFrame) begin
            fuseCnt <= fuseCnt - 8'd1;
            // Phase flips on every 4th frame counted inside the blink window
            if (blinkOn) begin
              blinkCnt <= blinkCnt + 2'd1;
              if (blinkCnt == 2'd3) blinkPhase <= ~blinkPhase;
            end
          end
        end
        EXPLODE: if (startOfFrame) begin
          if (expCnt == 8'd1) begin
            state      <= IDLE;
            bombActive <= 1'b0;
          end else begin
            expCnt <= expCnt - 8'd1;
          end
        end
        default: begin
          state      <= IDLE;
          bombActive <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller: placement, fuse, blink, explosion cross,
// early detonation, placement lockout and reset abort.
module tb_bomb_controller;
  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic [10:0] pixelX = '0, pixelY = '0;
  logic        placeBomb = 1'b0;
  logic [4:0]  playerTileX = '0;
  logic [3:0]  playerTileY = '0;
  logic        detonate = 1'b0;
  logic        bombDrawingRequest, explosionDrawingRequest, explodeStart, bombActive;
  logic [7:0]  bombRGB, explosionRGB;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  bomb_controller dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .pixelX(pixelX), .pixelY(pixelY), .placeBomb(placeBomb),
    .playerTileX(playerTileX), .playerTileY(playerTileY), .detonate(detonate),
    .bombDrawingRequest(bombDrawingRequest), .bombRGB(bombRGB),
    .explosionDrawingRequest(explosionDrawingRequest), .explosionRGB(explosionRGB),
    .explodeStart(explodeStart), .bombActive(bombActive)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (explodeStart) pulses++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic frame();
    startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
  endtask

  // Present tile-centre pixel and let the registered outputs catch up
  task automatic tile(input int x, input int y);
    pixelX = 11'(x * 32 + 16); pixelY = 11'(y * 32 + 16); tick();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, ".bReq"}, bombDrawingRequest, 0);
    chk({tag, ".bRGB"}, bombRGB, 0);
    chk({tag, ".eReq"}, explosionDrawingRequest, 0);
    chk({tag, ".eRGB"}, explosionRGB, 0);
    chk({tag, ".start"}, explodeStart, 0);
    chk({tag, ".active"}, bombActive, 0);
  endtask

  task automatic exp_tile(input string tag, input int x, input int y, input logic on);
    tile(x, y);
    chk({tag, ".eReq"}, explosionDrawingRequest, on);
    chk({tag, ".eRGB"}, explosionRGB, on ? 8'hF4 : 8'h00);
    chk({tag, ".bReq"}, bombDrawingRequest, 0);
  endtask

  initial begin
    // Reset state
    #12;
    all_zero("reset");
    resetN = 1'b1;
    tick();

    // Place at (5,3)
    playerTileX = 5'd5; playerTileY = 4'd3; placeBomb = 1'b1;
    tick(); placeBomb = 1'b0;
    chk("place.active", bombActive, 1);
    pixelX = 11'd160; pixelY = 11'd96; tick();
    chk("edge.bReq", bombDrawingRequest, 0);
    pixelX = 11'd164; pixelY = 11'd100; #1;
    chk("latency.bReq", bombDrawingRequest, 0);
    tick();
    chk("body.bReq", bombDrawingRequest, 1);
    chk("body.bRGB", bombRGB, 8'h00);
    chk("body.eReq", explosionDrawingRequest, 0);

    // placeBomb during FUSE is ignored
    playerTileX = 5'd9; playerTileY = 4'd9; placeBomb = 1'b1;
    tick(); placeBomb = 1'b0;
    tick();
    chk("lock.bReq", bombDrawingRequest, 1);
    pixelX = 11'd9 * 32 + 16; pixelY = 11'd9 * 32 + 16; tick();
    chk("lock.newtile", bombDrawingRequest, 0);
    pixelX = 11'd164; pixelY = 11'd100;

    // Fuse countdown with blink window: phase 1 once fuseCnt reaches 28, flips every 4
    for (int k = 1; k <= 119; k++) begin
      frame();
      if (k == 90 || k == 92 || k == 96 || k == 100) begin
        tick();
        chk($sformatf("blink.k%0d", k), bombRGB, (k == 92 || k == 100) ? 8'hE0 : 8'h00);
      end
    end
    chk("fuse.pulses", pulses, 0);
    chk("fuse.active", bombActive, 1);
    frame();
    chk("boom.start", explodeStart, 1);
    tick();
    chk("boom.startgone", explodeStart, 0);
    chk("boom.pulses", pulses, 1);

    // Explosion cross, RANGE 2
    for (int x = 3; x <= 7; x++) exp_tile($sformatf("armx%0d", x), x, 3, 1'b1);
    for (int y = 1; y <= 5; y++) exp_tile($sformatf("army%0d", y), 5, y, 1'b1);
    exp_tile("out.5_6", 5, 6, 1'b0);
    exp_tile("out.4_4", 4, 4, 1'b0);

    // detonate during EXPLODE neither restarts nor extends
    detonate = 1'b1; tick(); detonate = 1'b0;
    for (int k = 1; k <= 29; k++) frame();
    chk("exp29.active", bombActive, 1);
    frame();
    chk("exp30.active", bombActive, 0);
    chk("exp.pulses", pulses, 1);

    // detonate in IDLE does nothing
    detonate = 1'b1; tick(); tick(); detonate = 1'b0;
    chk("idledet.active", bombActive, 0);
    chk("idledet.pulses", pulses, 1);

    // Corner bomb, early detonate on fuse frame 10 (wins over startOfFrame)
    playerTileX = 5'd0; playerTileY = 4'd0; placeBomb = 1'b1;
    tick(); placeBomb = 1'b0;
    for (int k = 1; k <= 9; k++) frame();
    chk("det9.start", explodeStart, 0);
    detonate = 1'b1; startOfFrame = 1'b1; tick(); detonate = 1'b0; startOfFrame = 1'b0;
    chk("det.start", explodeStart, 1);
    chk("det.active", bombActive, 1);
    tick();
    chk("det.pulses", pulses, 2);
    for (int i = 0; i <= 2; i++) exp_tile($sformatf("cx%0d", i), i, 0, 1'b1);
    for (int i = 1; i <= 2; i++) exp_tile($sformatf("cy%0d", i), 0, i, 1'b1);
    exp_tile("c.3_0", 3, 0, 1'b0);
    exp_tile("c.0_3", 0, 3, 1'b0);
    exp_tile("c.1_1", 1, 1, 1'b0);
    pixelX = 11'd639; pixelY = 11'd16; tick();
    chk("nowrap.x639", explosionDrawingRequest, 0);
    pixelX = 11'd1024; pixelY = 11'd16; tick();
    chk("offscreen.x1024", explosionDrawingRequest, 0);

    // placeBomb held through end of explosion places on first IDLE clk
    playerTileX = 5'd7; playerTileY = 4'd7; placeBomb = 1'b1;
    for (int k = 1; k <= 30; k++) frame();
    chk("hold.idle", bombActive, 0);
    tick(); placeBomb = 1'b0;
    chk("hold.placed", bombActive, 1);
    tile(7, 7);
    chk("hold.bReq", bombDrawingRequest, 1);

    // Reset mid-EXPLODE
    detonate = 1'b1; tick(); detonate = 1'b0;
    chk("rst.start", explodeStart, 1);
    tick();
    chk("rst.eReq", explosionDrawingRequest, 1);
    resetN = 1'b0; #1;
    all_zero("rstmid");
    tick(); tick();
    chk("rst.pulses", pulses, 3);
    resetN = 1'b1; tick();
    chk("rst.after", bombActive, 0);
    chk("rst.eReq2", explosionDrawingRequest, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
